nibble_serial_adder_ctrl: RTL

- Sequencer that performs a WIDTH-bit addition over several cycles using one external 4-bit carry-select adder slice.
- Accepts wide operands on a valid/ready input port and sends one 4-bit nibble pair per cycle to the slice, LSB nibble first.
- Registers the slice carry between nibbles, assembles the result, and returns it on a valid/ready output port.
- Acts as both the feeder and the consumer of the slice, so a wide add costs one slice of area.

---
 rtl/nibble_serial_adder_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_ctrl
//  Description : Performs a WIDTH-bit addition over WIDTH/4 cycles using one
//                external 4-bit adder slice. Operands are accepted on a
//                valid/ready port, fed to the slice one nibble pair per cycle
//                (LSB nibble first), the slice carry is registered between
//                nibbles, and the assembled sum is returned on a valid/ready
//                output port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i         rising-edge clock
//    rst_ni        asynchronous active-low reset
//    in_valid_i    operand request
//    in_ready_o    block can accept operands (high only in IDLE)
//    in_a_i        operand A            [WIDTH-1:0]
//    in_b_i        operand B            [WIDTH-1:0]
//    in_cin_i      carry-in of the wide add
//    slice_a_o     current nibble of A to the slice (0 outside RUN)
//    slice_b_o     current nibble of B to the slice (0 outside RUN)
//    slice_cin_o   carry into the slice (0 outside RUN)
//    slice_sum_i   slice sum, combinational return
//    slice_cout_i  slice carry-out, combinational return
//    out_valid_o   result available
//    out_ready_i   consumer accepts the result
//    out_sum_o     result sum            [WIDTH-1:0]
//    out_cout_o    result carry-out
//  Parameters
//    WIDTH         operand width; multiple of 4 and at least 8
// ============================================================================
module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   // operand port
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic             in_cin_i,
   // external 4-bit slice
   output logic [3:0]       slice_a_o,
   output logic [3:0]       slice_b_o,
   output logic             slice_cin_o,
   input  logic [3:0]       slice_sum_i,
   input  logic             slice_cout_i,
   // result port
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_sum_o,
   output logic             out_cout_o
);

   // -------------------------------------------------------------------------
   // Derived constants
   // -------------------------------------------------------------------------
   localparam int SLICES = WIDTH / 4;
   localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

   // Index value of the final nibble; the result is committed on this edge.
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

   // -------------------------------------------------------------------------
   // State encoding
   // -------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // -------------------------------------------------------------------------
   // Registers and their next-state values
   // -------------------------------------------------------------------------
   logic [1:0]       state_q,     state_d;
   logic [IDX_W-1:0] idx_q,       idx_d;
   logic             carry_q,     carry_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] b_q,         b_d;
   logic [WIDTH-1:0] asm_q,       asm_d;
   logic [WIDTH-1:0] out_sum_q,   out_sum_d;
   logic             out_cout_q,  out_cout_d;
   logic             out_valid_q, out_valid_d;

   // Handshake qualifiers
   logic in_fire;
   logic out_fire;
   logic last_nibble;

   assign in_fire     = in_valid_i  && in_ready_o;
   assign out_fire    = out_valid_q && out_ready_i;
   assign last_nibble = (idx_q == LAST_IDX);

   // -------------------------------------------------------------------------
   // Process 1: state and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         asm_q       <= '0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         asm_q       <= asm_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   // -------------------------------------------------------------------------
   // Process 2: next-state and datapath update
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      asm_d       = asm_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (in_fire) begin
               a_d     = in_a_i;
               b_d     = in_b_i;
               carry_d = in_cin_i;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // Each slice result enters from the MSB side, so after SLICES
            // shifts the first (least significant) nibble sits at [3:0].
            asm_d   = {slice_sum_i, asm_q[WIDTH-1:4]};
            carry_d = slice_cout_i;
            a_d     = {4'b0000, a_q[WIDTH-1:4]};
            b_d     = {4'b0000, b_q[WIDTH-1:4]};
            idx_d   = idx_q + IDX_W'(1);

            if (last_nibble) begin
               // The result register takes the assembly value including the
               // nibble produced this cycle; the final carry only appears on
               // the result carry-out.
               out_sum_d   = {slice_sum_i, asm_q[WIDTH-1:4]};
               out_cout_d  = slice_cout_i;
               out_valid_d = 1'b1;
               idx_d       = '0;
               state_d     = ST_DONE;
            end
         end

         ST_DONE: begin
            // Result and carry-out stay in place after the handshake until
            // the next completion overwrites them.
            if (out_fire) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Process 3: state-decoded outputs
   // -------------------------------------------------------------------------
   always_comb begin
      in_ready_o  = 1'b0;
      slice_a_o   = 4'h0;
      slice_b_o   = 4'h0;
      slice_cin_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready_o = 1'b1;
         end
         ST_RUN: begin
            slice_a_o   = a_q[3:0];
            slice_b_o   = b_q[3:0];
            slice_cin_o = carry_q;
         end
         default: begin
            in_ready_o = 1'b0;
         end
      endcase
   end

   assign out_valid_o = out_valid_q;
   assign out_sum_o   = out_sum_q;
   assign out_cout_o  = out_cout_q;

endmodule
`default_nettype wire
